// File: rtl/frame_reader_pkg.sv
// Shared types and constants for the frame stream reader slice.
package frame_reader_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_t;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned IMG_BASE   = 256;
  localparam int unsigned IMG_WORDS  = 76800;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry synchronous FIFO; simultaneous push and pop are both honoured,
// including a push into a full FIFO that is being popped in the same cycle.
module stream_fifo2 #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] slots [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty    = (count == 2'd0);
  assign full     = (count == 2'd2);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign data_out = slots[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        slots[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= data_in;
        wr_ptr        <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_stream_reader.sv
// Read-side initiator: reads a range of words from single-port memory and
// streams them out over a valid/ready handshake through a 2-entry buffer.
module frame_stream_reader #(
  parameter int unsigned N          = 32,
  parameter int unsigned M          = 77056,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] base_addr,
  input  logic [N-1:0] length,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         mem_wr,
  output logic [N-1:0] mem_address,
  input  logic [N-1:0] mem_data_out,
  output logic [N-1:0] pix_data,
  output logic         pix_valid,
  input  logic         pix_ready
);

  import frame_reader_pkg::*;

  if (FIFO_DEPTH != frame_reader_pkg::FIFO_DEPTH) begin : g_bad_depth
    $error("frame_stream_reader supports only a 2-entry output buffer");
  end

  rd_state_t    state;
  rd_state_t    state_nxt;
  logic [N-1:0] cur_addr;
  logic [N-1:0] remaining;
  logic         rd_pend;
  logic         done_nxt;
  logic         err_nxt;
  logic         accept;
  logic         issue;
  logic         pop;
  logic [N:0]   end_addr;
  logic         range_bad;
  logic [1:0]   fifo_count;
  logic         fifo_full;
  logic         fifo_empty;
  logic [2:0]   occupancy;

  assign mem_wr      = 1'b0;
  assign mem_address = cur_addr;
  assign pix_valid   = !fifo_empty;
  assign pop         = pix_valid & pix_ready;

  // Sum carried at N+1 bits so a base near the top of the address space cannot wrap past the check.
  assign end_addr  = {1'b0, base_addr} + {1'b0, length};
  assign range_bad = end_addr > (N+1)'(M);
  assign accept    = (state == IDLE) && start && !range_bad && (length != '0);

  // Buffered plus in-flight words, less the one leaving this cycle, must stay below two.
  assign occupancy = {1'b0, fifo_count} + {2'b00, rd_pend};
  assign issue     = (state == RUN) && !(fifo_full && !pop)
                     && (occupancy < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (range_bad) begin
            err_nxt = 1'b1;
          end else if (length == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (issue && (remaining == N'(1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!rd_pend && fifo_empty) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      remaining <= '0;
      rd_pend   <= 1'b0;
    end else begin
      if (accept) begin
        cur_addr  <= base_addr;
        remaining <= length;
      end else if (issue) begin
        cur_addr  <= cur_addr + N'(1);
        remaining <= remaining - N'(1);
      end
      rd_pend <= issue;
    end
  end

  stream_fifo2 #(.W(N)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rd_pend),
    .pop      (pop),
    .data_in  (mem_data_out),
    .data_out (pix_data),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_frame_stream_reader.sv
// Bench for frame_stream_reader: memory holds mem[k]=k+100; a transfer-level
// model predicts the word stream, busy/done/err timing and handshake rules.
`timescale 1ns/1ps
module tb_frame_stream_reader;

  localparam int unsigned N = 32;
  localparam int unsigned M = 77056;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] base_addr = '0;
  logic [N-1:0] length = '0;
  logic         busy, done, err, mem_wr;
  logic [N-1:0] mem_address, mem_data_out, pix_data;
  logic         pix_valid;
  logic         pix_ready = 1'b1;

  logic [N-1:0] mem [M];

  int tests = 0;
  int fails = 0;

  // transfer-level model state
  int           cyc = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] got_q[$];
  bit           m_active = 0;
  int           busy_from = 0;
  int           first_valid_due = 0;
  int           done_due = -1;
  int           err_due = -1;
  int           start_cyc = 0;
  int           last_done_cyc = -1;
  int           last_err_cyc = -1;
  int           first_valid_cyc = -1;
  int           done_count = 0;
  int           pops = 0;
  logic         prev_valid = 1'b0;
  logic         prev_ready = 1'b0;
  logic [N-1:0] prev_data = '0;

  frame_stream_reader #(.N(N), .M(M), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .mem_wr       (mem_wr),
    .mem_address  (mem_address),
    .mem_data_out (mem_data_out),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_address < M) mem_data_out <= mem[mem_address];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      m_active   = 0;
      done_due   = -1;
      err_due    = -1;
      prev_valid = 1'b0;
    end else begin
      check("mem_wr", mem_wr, 0);
      check("done", done, (cyc == done_due));
      check("err", err, (cyc == err_due));
      if (done) begin
        last_done_cyc = cyc;
        done_count++;
      end
      if (err) last_err_cyc = cyc;
      if (cyc == done_due) m_active = 0;
      check("busy", busy, (m_active && cyc >= busy_from));

      if (m_active && cyc < first_valid_due) check("valid_early", pix_valid, 0);
      else if (m_active && cyc == first_valid_due) check("first_valid", pix_valid, 1);
      else if (exp_q.size() != 0) check("no_gap", pix_valid, 1);
      else check("no_extra", pix_valid, 0);

      if (prev_valid && !prev_ready && pix_valid) check("hold", pix_data, prev_data);
      if (pix_valid && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

      if (pix_valid && pix_ready && exp_q.size() != 0) begin
        check("pix_data", pix_data, exp_q[0]);
        got_q.push_back(pix_data);
        void'(exp_q.pop_front());
        pops++;
        if (exp_q.size() == 0) done_due = cyc + 2;
      end

      prev_valid = pix_valid;
      prev_ready = pix_ready;
      prev_data  = pix_data;

      if (start && !m_active) begin
        start_cyc = cyc;
        if (longint'(base_addr) + longint'(length) > longint'(M)) begin
          err_due = cyc + 1;
        end else if (length == 0) begin
          done_due = cyc + 1;
        end else begin
          for (int unsigned k = 0; k < length; k++) exp_q.push_back(base_addr + N'(k) + N'(100));
          m_active        = 1;
          busy_from       = cyc + 1;
          first_valid_due = cyc + 3;
        end
      end
    end
  end

  task automatic do_start(input logic [N-1:0] b, input logic [N-1:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_active || busy) && n < budget) begin
      @(posedge clk); n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("idle_timeout", m_active, 0);
  endtask

  task automatic clear_obs();
    got_q.delete();
    first_valid_cyc = -1;
  endtask

  task automatic check_seq(input string name, input int unsigned first, input int unsigned n);
    check({name, "_len"}, got_q.size(), n);
    for (int i = 0; i < got_q.size() && i < int'(n); i++) check(name, got_q[i], first + i);
  endtask

  initial begin
    int n;
    int pops0;
    int dc0;
    for (int k = 0; k < int'(M); k++) mem[k] = N'(k + 100);

    #3;
    check("rst_busy", busy, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_data", pix_data, 0);
    check("rst_addr", mem_address, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // full throughput
    clear_obs();
    do_start(256, 4);
    wait_idle(100);
    check_seq("t1_seq", 356, 4);
    check("t1_first_lat", first_valid_cyc - start_cyc, 3);
    check("t1_done_lat", last_done_cyc - start_cyc, 8);

    // back-pressure pattern 1,0,0 repeating
    clear_obs();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          pix_ready = (i % 3 == 0);
          @(posedge clk); #1;
        end
        pix_ready = 1'b1;
      end
      begin
        do_start(256, 4);
        wait_idle(100);
      end
    join
    check_seq("t2_seq", 356, 4);

    // zero length
    do_start(256, 0);
    wait_idle(20);
    check("t3_done_lat", last_done_cyc - start_cyc, 1);

    // out of range
    do_start(77000, 100);
    wait_idle(20);
    check("t4_err_lat", last_err_cyc - start_cyc, 1);
    check("t4_no_reads", mem_address, 260);

    // range boundaries: exact fit accepted, one past rejected, 33-bit overflow rejected
    clear_obs();
    do_start(N'(M - 3), 3);
    wait_idle(50);
    check_seq("t5_top", M - 3 + 100, 3);
    do_start(N'(M - 2), 3);
    wait_idle(20);
    check("t5_over_err", last_err_cyc - start_cyc, 1);
    do_start(32'hFFFF_FFF0, 32'h20);
    wait_idle(20);
    check("t5_wrap_err", last_err_cyc - start_cyc, 1);

    // second start while busy is ignored
    clear_obs();
    dc0 = done_count;
    do_start(256, 6);
    repeat (2) @(posedge clk);
    do_start(500, 3);
    wait_idle(100);
    check_seq("t6_seq", 356, 6);
    check("t6_one_done", done_count - dc0, 1);

    // reset mid-transfer
    clear_obs();
    pops0 = pops;
    do_start(1000, 10);
    n = 0;
    while (pops < pops0 + 3 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("t7_pop_timeout", (pops >= pops0 + 3), 1);
    #1 rst_n = 1'b0;
    #1;
    check("t7_busy", busy, 0);
    check("t7_valid", pix_valid, 0);
    check("t7_data", pix_data, 0);
    check("t7_addr", mem_address, 0);
    check("t7_done", done, 0);
    check("t7_err", err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    dc0 = done_count;
    repeat (5) @(posedge clk);
    #1;
    check("t7_no_done", done_count - dc0, 0);
    clear_obs();
    do_start(0, 2);
    wait_idle(50);
    check_seq("t7_seq", 100, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
